// File: rtl/string_length_arbiter_pkg.sv
// Shared constants and types for the string length arbiter and its length finder.
package string_length_arbiter_pkg;

    localparam int STR_W     = 64;
    localparam int LEN_W     = 4;
    localparam int ID_W      = 1;
    localparam int NUM_BYTES = STR_W / 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/string_length_arbiter_length_finder.sv
// Combinational length of a null-terminated string packed LSB-first into a word.
module length_finder
    import string_length_arbiter_pkg::*;
(
    input  logic [STR_W-1:0] str,
    output logic [LEN_W-1:0] length
);

    logic [NUM_BYTES-1:0] zero_flags;

    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_zero
            assign zero_flags[gi] = (str[gi*8 +: 8] == 8'h00);
        end
    endgenerate

    // Scan from the top byte down so the lowest zero byte wins.
    always_comb begin
        length = LEN_W'(NUM_BYTES);
        for (int i = NUM_BYTES - 1; i >= 0; i--) begin
            if (zero_flags[i]) begin
                length = LEN_W'(i);
            end
        end
    end

endmodule

// File: rtl/string_length_arbiter.sv
// Round-robin arbiter sharing one length_finder between two string requesters,
// returning registered lengths tagged with the requester ID on a valid/ready channel.
module string_length_arbiter
    import string_length_arbiter_pkg::*;
#(
    parameter bit PRIORITY_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [STR_W-1:0] req0_string,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [STR_W-1:0] req1_string,
    output logic             req1_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [LEN_W-1:0] resp_length,
    output logic [ID_W-1:0]  resp_id
);

    state_t           state_reg, state_next;
    logic [ID_W-1:0]  last_id_reg;
    logic [LEN_W-1:0] resp_length_reg;
    logic [ID_W-1:0]  resp_id_reg;

    logic             grant0, grant1;
    logic             can_accept;
    logic             accept;
    logic [ID_W-1:0]  grant_id;
    logic [STR_W-1:0] sel_string;
    logic [LEN_W-1:0] sel_length;

    // On contention the requester that did not win last time takes the grant.
    assign grant0 = req0_valid & (~req1_valid | (last_id_reg == ID_W'(1)));
    assign grant1 = req1_valid & (~req0_valid | (last_id_reg == ID_W'(0)));

    assign can_accept = (state_reg == ST_EMPTY) | resp_ready;
    assign accept     = can_accept & (grant0 | grant1) & ~reset;
    assign grant_id   = grant1 ? ID_W'(1) : ID_W'(0);

    // Readies are forced low while reset is held so nothing is consumed into a discarded slot.
    assign req0_ready = can_accept & grant0 & ~reset;
    assign req1_ready = can_accept & grant1 & ~reset;

    assign sel_string = grant1 ? req1_string : req0_string;

    length_finder u_length_finder (
        .str    (sel_string),
        .length (sel_length)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (resp_ready && !accept) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_EMPTY;
            last_id_reg     <= ~ID_W'(PRIORITY_INIT);
            resp_length_reg <= '0;
            resp_id_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                last_id_reg     <= grant_id;
                resp_length_reg <= sel_length;
                resp_id_reg     <= grant_id;
            end
        end
    end

    assign resp_valid  = (state_reg == ST_FULL);
    assign resp_length = resp_length_reg;
    assign resp_id     = resp_id_reg;

endmodule

// File: tb/tb_string_length_arbiter.sv
// Directed bench for string_length_arbiter: reset, lengths, contention, backpressure, drain, mid-run reset.
module tb_string_length_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [63:0] req0_string;
    logic        req0_ready;
    logic        req1_valid;
    logic [63:0] req1_string;
    logic        req1_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_length;
    logic [0:0]  resp_id;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [63:0] STR_LEN2 = 64'h0000_0000_0000_4241;
    localparam logic [63:0] STR_LEN3 = 64'h0000_0000_0043_4241;
    localparam logic [63:0] STR_LEN5 = 64'h0000_0045_4443_4241;
    localparam logic [63:0] STR_LEN8 = 64'h4141_4141_4141_4141;

    string_length_arbiter #(.PRIORITY_INIT(1'b0)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_string (req0_string),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_string (req1_string),
        .req1_ready  (req1_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_length (resp_length),
        .resp_id     (resp_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_resp(input string name, input logic exp_valid,
                              input logic [3:0] exp_len, input logic exp_id);
        // Not a shared comparator: only formats the per-transaction trace line.
        $display("[TB] %s: resp_valid=%0b resp_length=%0d resp_id=%0d (expect %0b/%0d/%0d)",
                 name, resp_valid, resp_length, resp_id, exp_valid, exp_len, exp_id);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req0_string = STR_LEN2;
        req1_valid = 1'b1; req1_string = STR_LEN3;
        resp_ready = 1'b1;
        #3;
        tests_run++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        step();
        tests_run++;
        if (resp_valid !== 1'b0 || resp_length !== 4'd0 || resp_id !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_resp: got v=%b len=%0d id=%0d want 0/0/0", resp_valid, resp_length, resp_id);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        step();
        tests_run++;
        if (resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: resp_valid got %b want 0", resp_valid);
        end
        check_resp("reset", 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_single();
        req0_string = STR_LEN2; req0_valid = 1'b1; resp_ready = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_length !== 4'd2 || resp_id !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_resp: got v=%b len=%0d id=%0d want 1/2/0", resp_valid, resp_length, resp_id);
        end
        check_resp("single", 1'b1, 4'd2, 1'b0);
    endtask

    task automatic test_no_null();
        req1_string = STR_LEN8; req1_valid = 1'b1; resp_ready = 1'b1;
        step();
        req1_valid = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_length !== 4'b1000 || resp_id !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL no_null_len8: got v=%b len=%0d id=%0d want 1/8/1", resp_valid, resp_length, resp_id);
        end
        check_resp("no_null", 1'b1, 4'd8, 1'b1);
        req0_string = 64'h0; req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_length !== 4'd0 || resp_id !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL all_zero_len0: got v=%b len=%0d id=%0d want 1/0/0", resp_valid, resp_length, resp_id);
        end
        check_resp("all_zero", 1'b1, 4'd0, 1'b0);
        step();
    endtask

    task automatic test_contention();
        reset = 1'b1;
        req0_string = STR_LEN3; req1_string = STR_LEN5;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        step();
        #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL contention_first_grant: got %b%b want 10", req0_ready, req1_ready);
        end
        for (int i = 0; i < 6; i++) begin
            logic       exp_id;
            logic [3:0] exp_len;
            exp_id  = (i % 2 == 1);
            exp_len = exp_id ? 4'd5 : 4'd3;
            step();
            tests_run++;
            if (resp_valid !== 1'b1 || resp_id !== exp_id || resp_length !== exp_len) begin
                tests_failed++;
                $display("[TB] FAIL contention_%0d: got v=%b len=%0d id=%0d want 1/%0d/%0d",
                         i, resp_valid, resp_length, resp_id, exp_len, exp_id);
            end
            check_resp("contention", 1'b1, exp_len, exp_id);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        // Held result is id 1 / length 5 from the last contention cycle.
        resp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL backpressure_ready_%0d: got %b%b want 00", i, req0_ready, req1_ready);
            end
            step();
            tests_run++;
            if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_length !== 4'd5) begin
                tests_failed++;
                $display("[TB] FAIL backpressure_hold_%0d: got v=%b len=%0d id=%0d want 1/5/1",
                         i, resp_valid, resp_length, resp_id);
            end
            check_resp("backpressure", 1'b1, 4'd5, 1'b1);
        end
        resp_ready = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_release_ready: got %b%b want 10", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_length !== 4'd3) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_new: got v=%b len=%0d id=%0d want 1/3/0", resp_valid, resp_length, resp_id);
        end
        check_resp("backpressure_release", 1'b1, 4'd3, 1'b0);
    endtask

    task automatic test_drain();
        resp_ready = 1'b1;
        step();
        tests_run++;
        if (resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL drain_empty: resp_valid got %b want 0", resp_valid);
        end
        req1_string = STR_LEN5; req1_valid = 1'b1;
        #1;
        tests_run++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL drain_reaccept_ready: got %b%b want 01", req0_ready, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_length !== 4'd5) begin
            tests_failed++;
            $display("[TB] FAIL drain_reaccept: got v=%b len=%0d id=%0d want 1/5/1", resp_valid, resp_length, resp_id);
        end
        check_resp("drain", 1'b1, 4'd5, 1'b1);
        step();
    endtask

    task automatic test_reset_mid_full();
        // Leaves last_id at 0, so without a reset contention would grant requester 1.
        req0_string = STR_LEN3; req0_valid = 1'b1; resp_ready = 1'b1;
        step();
        req0_valid = 1'b0; resp_ready = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_length !== 4'd3) begin
            tests_failed++;
            $display("[TB] FAIL midreset_fill: got v=%b len=%0d id=%0d want 1/3/0", resp_valid, resp_length, resp_id);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_async_clear: resp_valid got %b want 0", resp_valid);
        end
        req0_string = STR_LEN3; req1_string = STR_LEN5;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_ready_low: got %b%b want 00", req0_ready, req1_ready);
        end
        step();
        tests_run++;
        if (resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_no_inflight: resp_valid got %b want 0", resp_valid);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_priority: got %b%b want 10", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_length !== 4'd3) begin
            tests_failed++;
            $display("[TB] FAIL midreset_first: got v=%b len=%0d id=%0d want 1/3/0", resp_valid, resp_length, resp_id);
        end
        check_resp("reset_mid_full", 1'b1, 4'd3, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_string = '0;
        req1_valid = 1'b0; req1_string = '0;
        resp_ready = 1'b0;
        test_reset();
        test_single();
        test_no_null();
        test_contention();
        test_backpressure();
        test_drain();
        test_reset_mid_full();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/string_length_arbiter.md
# string_length_arbiter

Shares a single `length_finder` between two requesters, each presenting a 64-bit null-terminated string (byte 0 in bits [7:0]). The block grants requesters round-robin and registers the selected string's length. It returns the length with the requester ID over a valid/ready response channel. Throughput is one string per cycle when the response side is not stalled. It sits between the string producers and any consumer that needs string lengths.

## Interface
- `PRIORITY_INIT`, default 0: requester that wins a tie on the first arbitration after reset (0 or 1).
- `clk` input 1: sole clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req0_valid` input 1: requester 0 presents a string.
- `req0_string` input 64: requester 0 string; must hold stable while `req0_valid` is high and `req0_ready` is low.
- `req0_ready` output 1: requester 0 string accepted this cycle when high together with `req0_valid`.
- `req1_valid`, `req1_string`, `req1_ready`: same as requester 0, for requester 1.
- `resp_valid` output 1: response registers hold a result.
- `resp_ready` input 1: consumer accepts the response.
- `resp_length` output 4: index of the first all-zero byte, 0–7; value 8 when no byte is zero.
- `resp_id` output 1: requester that supplied the string.

## Operation
- FSM with two states:
  - EMPTY: no result held.
  - FULL: result held, `resp_valid`=1.
- `can_accept` = (state==EMPTY) | `resp_ready`.
- Grant logic (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester that is not `last_id` is granted.
  - None valid: no grant.
- `reqN_ready` = `can_accept` & grant[N]. Ready may depend on valid. At most one ready is high in any cycle.
- Accept (a grant while `can_accept` is high):
  - The granted string is muxed into `length_finder`.
  - On the next edge, `resp_length`, `resp_id` and `last_id` are loaded with the result and requester.
  - State becomes FULL.
- In FULL with `resp_ready`=1 and no accept: state goes to EMPTY. Response registers keep their old values but are don't-care.
- In FULL with `resp_ready`=1 and an accept in the same cycle: state stays FULL and the response registers load the new result. This is back-to-back operation.
- In FULL with `resp_ready`=0: all outputs hold, both `reqN_ready`=0.
- `last_id` changes only on an accept.
- Reset values:
  - state EMPTY, `resp_valid`=0.
  - `resp_length`=0, `resp_id`=0.
  - `last_id`=~`PRIORITY_INIT`.
  - Both `reqN_ready`=0 while reset is asserted.

## Timing
- Latency: accept at edge N gives `resp_valid`=1 with the result after edge N. The response is visible in the cycle following the handshake.
- Throughput: one accept per cycle while `resp_ready`=1.
- No combinational path from `reqN_string` to any output.
- Combinational paths exist from `resp_ready` and `reqN_valid` to `reqN_ready`.
- Under simultaneous requests with continuous `resp_ready`, grants strictly alternate (0,1,0,1 … for `PRIORITY_INIT`=0).
- Reset asserted mid-operation:
  - The held response is discarded immediately (asynchronously).
  - No response is produced for the string in flight.
  - Arbitration restarts from `PRIORITY_INIT`.
- A requester held valid while ungranted waits at most one accept.

## Structure
- Shared constants header: `STR_W`=64, `LEN_W`=4, `ID_W`=1, state encodings EMPTY/FULL.
- Sub-module: one instance of the existing `length_finder`, fed by the 2:1 grant mux. The instance is not duplicated per requester.
- Everything else is the FSM, the round-robin pointer and the response registers, kept in this module.

## Test plan
- Single request:
  - Stimulus: `req0_string`=64'h0000_0000_0000_4241, only `req0_valid`, `resp_ready`=1.
  - Response: `req0_ready`=1 in the same cycle; next cycle `resp_valid`=1, `resp_length`=2, `resp_id`=0.
- No null byte:
  - Stimulus: `req1_string`=64'h4141_4141_4141_4141.
  - Response: `resp_length`=8 (4'b1000), `resp_id`=1. Also send an all-zero string and check `resp_length`=0.
- Contention:
  - Stimulus: both valid from reset with `PRIORITY_INIT`=0, `resp_ready`=1, six cycles.
  - Response: `resp_id` sequence 0,1,0,1,0,1; one result per cycle.
- Backpressure:
  - Stimulus: result held, `resp_ready`=0 for 3 cycles while both requests are valid.
  - Response: `resp_*` stable and both `reqN_ready`=0 for those cycles. On the cycle `resp_ready` rises, an accept occurs and the new result appears one cycle later.
- Drain to empty:
  - Stimulus: one response accepted with no pending requests.
  - Response: `resp_valid` falls to 0 on the next cycle; a later request is accepted immediately.
- Reset mid-FULL:
  - Stimulus: assert `reset` asynchronously between edges while `resp_valid`=1.
  - Response: `resp_valid`=0 before the next edge. After release with both requests valid, the first grant goes to `PRIORITY_INIT`.
